// File: rtl/byte_serial_tx_pkg.sv
// Shared types and line-level constants for the byte serial transmitter
// and the receiver that will reuse its bit timing.
package byte_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

endpackage

// File: rtl/bit_tick_divider.sv
// Modulo-CLKS_PER_BIT counter that marks each serial bit boundary with a
// one-cycle terminal-count tick. Holds while en is low; clear wins over en.
module bit_tick_divider #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // The tick only fires in an enabled cycle so a frozen caller never advances
  assign tick = en && !clear && (count == TERMINAL);

  // Count 0..CLKS_PER_BIT-1, wrapping at the terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == TERMINAL) count <= '0;
      else                   count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/byte_serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, DATA_W data bits LSB
// first, one stop bit, on a line that idles high. Valid/ready upstream.
module byte_serial_tx
  import byte_serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              enable,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  tx_state_t         state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [BCW-1:0]    bitcnt, bitcnt_next;
  logic              done_pending, done_pending_next;
  logic              accept;
  logic              bit_tick;

  assign din_ready = (state == IDLE) && enable && !reset;
  assign accept    = din_valid && din_ready;
  assign busy      = (state != IDLE);
  // A completion seen just before a freeze is held until enable returns
  assign done      = done_pending && enable;

  bit_tick_divider #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_divider (
    .clk  (clk),
    .reset(reset),
    .en   (enable),
    .clear(state == IDLE),
    .tick (bit_tick)
  );

  // State, shift register, bit counter and pending-done registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bitcnt       <= '0;
      done_pending <= 1'b0;
    end else begin
      state        <= state_next;
      shreg        <= shreg_next;
      bitcnt       <= bitcnt_next;
      done_pending <= done_pending_next;
    end
  end

  // Frame sequencing and line level; everything holds while enable is low
  always_comb begin
    state_next        = state;
    shreg_next        = shreg;
    bitcnt_next       = bitcnt;
    done_pending_next = enable ? 1'b0 : done_pending;
    tx                = TX_IDLE_LEVEL;
    case (state)
      IDLE: begin
        tx = TX_IDLE_LEVEL;
        if (accept) begin
          state_next = START;
          shreg_next = din;
        end
      end
      START: begin
        tx = START_BIT;
        if (bit_tick) begin
          state_next  = DATA;
          bitcnt_next = '0;
        end
      end
      DATA: begin
        tx = shreg[0];
        if (bit_tick) begin
          shreg_next = shreg >> 1;
          if (bitcnt == LAST_BIT) state_next = STOP;
          else                    bitcnt_next = bitcnt + 1'b1;
        end
      end
      STOP: begin
        tx = STOP_BIT;
        if (bit_tick) begin
          state_next        = IDLE;
          done_pending_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_byte_serial_tx.sv
// Self-checking bench for byte_serial_tx: per-cycle tx scoreboard fed by
// the stimulus, plus directed checks on handshake, timing, freeze, reset.
module tb_byte_serial_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       enable;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] din1;
  logic       din_valid1;
  logic       din_ready1;
  logic       enable1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int checks   = 0;
  int failures = 0;

  bit exp_bits[$];
  bit exp_bits1[$];
  logic prev_tx = 1'b1;

  byte_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .enable(enable), .tx(tx), .busy(busy), .done(done)
  );

  byte_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .enable(enable1), .tx(tx1), .busy(busy1), .done(done1)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected line levels for one frame, one entry per enabled cycle
  function automatic void pushFrame(input logic [7:0] data, input int cpb, input bit to_second);
    bit seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(data[i]);
    seq.push_back(1'b1);
    foreach (seq[k]) begin
      for (int c = 0; c < cpb; c++) begin
        if (to_second) exp_bits1.push_back(seq[k]);
        else           exp_bits.push_back(seq[k]);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for a single handshake cycle and push its frame
  task automatic applyStimulus(input logic [7:0] data, input bit hold_valid);
    pushFrame(data, CPB, 1'b0);
    din       = data;
    din_valid = 1'b1;
    #1;
    checkOutput("accept_ready", din_ready, 1'b1);
    tick();
    if (!hold_valid) din_valid = 1'b0;
    checkOutput("start_tx", tx, 1'b0);
    checkOutput("start_busy", busy, 1'b1);
  endtask

  // Walk one frame from its first START cycle up to the done cycle
  task automatic runFrame(input string tag, input int exp_len, input int frz_at,
                          input int frz_len, input bit scramble);
    int cyc;
    int busy_cnt;
    cyc = 1;
    busy_cnt = 0;
    while (cyc < 200) begin
      enable = !(cyc >= frz_at && cyc < frz_at + frz_len);
      #1;
      if (done) break;
      if (!enable) checkOutput({tag, "_no_done_frozen"}, done, 1'b0);
      if (busy) busy_cnt++;
      tick();
      if (scramble) din = 8'($urandom);
      cyc++;
    end
    enable = 1'b1;
    checkOutput({tag, "_done_cycle"}, cyc, exp_len + 1);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, exp_len);
    checkOutput({tag, "_done_idle_tx"}, tx, 1'b1);
    checkOutput({tag, "_done_ready"}, din_ready, 1'b1);
    checkOutput({tag, "_sb_empty"}, exp_bits.size(), 0);
  endtask

  // Scoreboard monitor: every enabled busy cycle pops one expected level
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (enable) begin
          if (exp_bits.size() == 0) checkOutput("unexpected_busy", 1, 0);
          else                      checkOutput("tx_bit", tx, exp_bits.pop_front());
        end else begin
          checkOutput("tx_hold", tx, prev_tx);
        end
        checkOutput("ready_while_busy", din_ready, 1'b0);
      end else begin
        checkOutput("tx_idle", tx, 1'b1);
      end
      prev_tx = tx;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; din = 8'h00; din_valid = 1'b0;
    din1 = 8'h00; din_valid1 = 1'b0; enable1 = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_tx", tx, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_ready", din_ready, 1'b0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", din_ready, 1'b1);
    tick();
    checkOutput("post_rst_tx", tx, 1'b1);
    checkOutput("post_rst_done", done, 1'b0);

    // Single frame 0xA5
    applyStimulus(8'hA5, 1'b0);
    runFrame("a5", 40, 0, 0, 1'b0);
    tick();
    checkOutput("a5_done_width", done, 1'b0);

    // Back-to-back 0x00 then 0xFF with din_valid held and din scrambled
    applyStimulus(8'h00, 1'b1);
    runFrame("b2b_00", 40, 0, 0, 1'b1);
    pushFrame(8'hFF, CPB, 1'b0);
    din = 8'hFF;
    tick();
    din_valid = 1'b0;
    checkOutput("b2b_start_tx", tx, 1'b0);
    checkOutput("b2b_start_busy", busy, 1'b1);
    checkOutput("b2b_done_cleared", done, 1'b0);
    runFrame("b2b_ff", 40, 0, 0, 1'b0);
    tick();

    // Enable dropped for 7 cycles in the middle of data bit 3
    applyStimulus(8'h3C, 1'b0);
    runFrame("freeze", 47, 18, 7, 1'b0);
    tick();

    // Enable low in IDLE blocks the handshake
    enable = 1'b0;
    din_valid = 1'b1;
    #1;
    checkOutput("disabled_ready", din_ready, 1'b0);
    tick();
    checkOutput("disabled_no_accept", busy, 1'b0);
    din_valid = 1'b0;
    enable = 1'b1;
    tick();

    // Reset in the middle of data bit 5 of 0x81
    applyStimulus(8'h81, 1'b0);
    for (int i = 1; i < 26; i++) tick();
    checkOutput("abort_pre_tx", tx, 1'b0);
    reset = 1'b1;
    exp_bits.delete();
    #1;
    checkOutput("abort_tx", tx, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ready", din_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("abort_done", done, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_no_done", done, 1'b0);
      checkOutput("abort_idle", busy, 1'b0);
    end
    applyStimulus(8'h55, 1'b0);
    runFrame("after_abort", 40, 0, 0, 1'b0);
    tick();

    // One clock per bit on the second instance
    pushFrame(8'h01, 1, 1'b1);
    din1 = 8'h01;
    din_valid1 = 1'b1;
    tick();
    din_valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (exp_bits1.size() == 0) checkOutput("cpb1_sb_underflow", 1, 0);
      else                       checkOutput("cpb1_tx", tx1, exp_bits1.pop_front());
      checkOutput("cpb1_no_done", done1, 1'b0);
      tick();
    end
    checkOutput("cpb1_done", done1, 1'b1);
    checkOutput("cpb1_idle_tx", tx1, 1'b1);
    tick();
    checkOutput("cpb1_done_width", done1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
